// File: rtl/wb_pkg.sv
// Shared types and constants for the memory-to-writeback stage.
//   wb_state_t : writeback FSM states
//   vec_t      : four 16-bit lanes, lane 0 in the least significant bits
package wb_pkg;

    localparam int unsigned LANES       = 4;
    localparam int unsigned LANE_W      = 16;
    localparam int unsigned LANE_STRIDE = 2;
    localparam int unsigned CNT_W       = $clog2(LANES) + 1;   // holds 0..LANES
    localparam int unsigned LANE_IDX_W  = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } wb_state_t;

    typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

endpackage

// File: rtl/vector_load_sequencer.sv
// Issues the four lane reads of a vector load and assembles the responses.
//   start      : capture base and clear counters/lane buffer
//   base       : byte address of lane 0
//   busy       : a load is in progress (requests/responses are honoured)
//   done       : the final lane response is arriving this cycle
//   lanes      : lane buffer including any response arriving this cycle
//   mem_*      : lane read port; responses return in request order
module vector_load_sequencer
    import wb_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WIDTH-1:0]  base,
    input  logic              busy,
    output logic              done,
    output vec_t              lanes,
    output logic              mem_req,
    output logic [WIDTH-1:0]  mem_addr,
    input  logic              mem_ready,
    input  logic [LANE_W-1:0] mem_rdata,
    input  logic              mem_rvalid
);

    logic [WIDTH-1:0] base_q;
    logic [CNT_W-1:0] req_cnt;
    logic [CNT_W-1:0] rsp_cnt;
    vec_t             lane_q;
    vec_t             lane_d;
    logic             rsp_take;

    // Address is forced to zero outside a load so the port idles at a known value.
    assign mem_req  = busy && (req_cnt < CNT_W'(LANES));
    assign mem_addr = busy ? (base_q + WIDTH'(LANE_STRIDE) * WIDTH'(req_cnt)) : '0;

    // Responses beyond the fourth, or outside a load, are dropped.
    assign rsp_take = busy && mem_rvalid && (rsp_cnt < CNT_W'(LANES));
    assign done     = rsp_take && (rsp_cnt == CNT_W'(LANES - 1));

    // Merge the arriving lane so the final lane is visible in the done cycle.
    always_comb begin
        lane_d = lane_q;
        if (rsp_take) begin
            lane_d[rsp_cnt[LANE_IDX_W-1:0]] = mem_rdata;
        end
    end

    assign lanes = lane_d;

    // Counter and lane buffer state.
    always_ff @(posedge clk) begin
        if (reset) begin
            base_q  <= '0;
            req_cnt <= '0;
            rsp_cnt <= '0;
            lane_q  <= '0;
        end else if (start) begin
            base_q  <= base;
            req_cnt <= '0;
            rsp_cnt <= '0;
            lane_q  <= '0;
        end else begin
            if (mem_req && mem_ready) begin
                req_cnt <= req_cnt + CNT_W'(1);
            end
            if (rsp_take) begin
                rsp_cnt <= rsp_cnt + CNT_W'(1);
            end
            lane_q <= lane_d;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Memory-to-writeback stage: registers scalar results into the W stage and
// sequences vector loads (four lane reads) into a single vector write.
//   ValidM..VectorResultM : M-stage instruction
//   mem_*                 : lane read port to data memory
//   StallM                : holds the M stage while a vector load is in flight
//   *W                    : register-file write side (all registered)
module writeback_unit
    import wb_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ValidM,
    input  logic              RegWriteM,
    input  logic              MemToRegM,
    input  logic              VectorLoadM,
    input  logic              VectorRegWriteM,
    input  logic [4:0]        WA3M,
    input  logic [WIDTH-1:0]  ResultM,
    input  vec_t              VectorResultM,
    output logic              mem_req,
    output logic [WIDTH-1:0]  mem_addr,
    input  logic              mem_ready,
    input  logic [LANE_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic              StallM,
    output logic              RegWriteW,
    output logic              MemToRegW,
    output logic              VectorRegWriteW,
    output logic [4:0]        WA3W,
    output logic [WIDTH-1:0]  ResultW,
    output vec_t              VectorResultW
);

    wb_state_t        state_q;
    wb_state_t        state_d;
    logic             accept;
    logic             start;
    logic             done;
    vec_t             lanes;
    logic [4:0]       wa3_load_q;
    logic [4:0]       wa3_load_d;
    logic             rw_d;
    logic             mtr_d;
    logic             vrw_d;
    logic [4:0]       wa3_d;
    logic [WIDTH-1:0] res_d;
    vec_t             vec_d;

    vector_load_sequencer #(.WIDTH(WIDTH)) u_seq (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base       (ResultM),
        .busy       (state_q == LOAD),
        .done       (done),
        .lanes      (lanes),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    assign accept = ValidM && !StallM;

    // Next state and next W-stage values; data fields hold when not written.
    always_comb begin
        state_d    = IDLE;
        start      = 1'b0;
        wa3_load_d = wa3_load_q;
        rw_d       = 1'b0;
        mtr_d      = 1'b0;
        vrw_d      = 1'b0;
        wa3_d      = WA3W;
        res_d      = ResultW;
        vec_d      = VectorResultW;
        case (state_q)
            LOAD: begin
                state_d = LOAD;
                if (done) begin
                    state_d = COMMIT;
                    vrw_d   = 1'b1;
                    wa3_d   = wa3_load_q;
                    vec_d   = lanes;
                end
            end
            default: begin
                if (accept && VectorLoadM) begin
                    state_d    = LOAD;
                    start      = 1'b1;
                    wa3_load_d = WA3M;
                end else if (accept) begin
                    rw_d  = RegWriteM;
                    mtr_d = MemToRegM;
                    vrw_d = VectorRegWriteM;
                    wa3_d = WA3M;
                    res_d = ResultM;
                    vec_d = VectorResultM;
                end
            end
        endcase
    end

    // State, stall and W-stage registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= IDLE;
            StallM          <= 1'b0;
            wa3_load_q      <= '0;
            RegWriteW       <= 1'b0;
            MemToRegW       <= 1'b0;
            VectorRegWriteW <= 1'b0;
            WA3W            <= '0;
            ResultW         <= '0;
            VectorResultW   <= '0;
        end else begin
            state_q         <= state_d;
            StallM          <= (state_d == LOAD);
            wa3_load_q      <= wa3_load_d;
            RegWriteW       <= rw_d;
            MemToRegW       <= mtr_d;
            VectorRegWriteW <= vrw_d;
            WA3W            <= wa3_d;
            ResultW         <= res_d;
            VectorResultW   <= vec_d;
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: directed cases plus random traffic
// against an address-keyed memory model and a lane-level load model.
module tb_writeback_unit;
    import wb_pkg::*;

    localparam int unsigned WIDTH = 64;

    logic             clk;
    logic             reset;
    logic             ValidM, RegWriteM, MemToRegM, VectorLoadM, VectorRegWriteM;
    logic [4:0]       WA3M;
    logic [WIDTH-1:0] ResultM;
    vec_t             VectorResultM;
    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_ready;
    logic [15:0]      mem_rdata;
    logic             mem_rvalid;
    logic             StallM, RegWriteW, MemToRegW, VectorRegWriteW;
    logic [4:0]       WA3W;
    logic [WIDTH-1:0] ResultW;
    vec_t             VectorResultW;

    writeback_unit #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .ValidM(ValidM), .RegWriteM(RegWriteM),
        .MemToRegM(MemToRegM), .VectorLoadM(VectorLoadM),
        .VectorRegWriteM(VectorRegWriteM), .WA3M(WA3M), .ResultM(ResultM),
        .VectorResultM(VectorResultM), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .StallM(StallM), .RegWriteW(RegWriteW), .MemToRegW(MemToRegW),
        .VectorRegWriteW(VectorRegWriteW), .WA3W(WA3W), .ResultW(ResultW),
        .VectorResultW(VectorResultW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rw, mtr, vrw;
        logic [4:0]  wa3;
        logic [63:0] result;
        logic [63:0] vec;
        bit          chk_result;
        int          exp_cyc;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          stall_cycles = 0;
    int          vcommits = 0;
    int          last_vcommit = -1;
    logic [63:0] last_vec = '0;

    logic [15:0] pend[$];
    logic [63:0] hs_addr[$];
    logic [63:0] held[$];
    int          ready_mode = 0;   // 0 always ready, 1 random, 2 scripted hold
    int          lat_mode = 0;     // 0 one-cycle latency, 1 random extra latency
    int          hold_left = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory content is a function of the byte address.
    function automatic logic [15:0] mem_f(input logic [63:0] a);
        logic [63:0] d;
        d = (a - 64'h100) >> 1;
        return (d[15:0] + 16'h00A0) ^ a[47:32];
    endfunction

    // A vector load returns the four halfwords at base, base+2, base+4, base+6.
    function automatic logic [63:0] ref_vec(input logic [63:0] b);
        logic [63:0] v;
        for (int i = 0; i < 4; i++) v[i*16 +: 16] = mem_f(b + 64'(2 * i));
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Memory: responses in order, at least one cycle after the handshake.
    initial begin
        logic r;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = 16'($urandom);
            if (pend.size() > 0 && (lat_mode == 0 || $urandom_range(0, 2) != 0)) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend.pop_front();
            end
            r = (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (ready_mode == 2 && mem_req === 1'b1 && hs_addr.size() == 1 && hold_left > 0) begin
                r = 1'b0;
                hold_left--;
                held.push_back(mem_addr);
            end
            mem_ready = r;
            if (mem_req === 1'b1 && r) begin
                pend.push_back(mem_f(mem_addr));
                hs_addr.push_back(mem_addr);
            end
        end
    end

    // Monitor: every W write must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        bit   bad;
        forever begin
            @(negedge clk);
            if (StallM === 1'b1) stall_cycles++;
            if (VectorRegWriteW === 1'b1) begin
                vcommits++;
                last_vcommit = cyc;
                last_vec = VectorResultW;
            end
            if (RegWriteW === 1'b1 || MemToRegW === 1'b1 || VectorRegWriteW === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write cyc=%0d: got rw=%b mtr=%b vrw=%b wa3=%0d, required no write",
                             cyc, RegWriteW, MemToRegW, VectorRegWriteW, WA3W);
                end else begin
                    e = sb.pop_front();
                    bad = ({RegWriteW, MemToRegW, VectorRegWriteW} !== {e.rw, e.mtr, e.vrw}) ||
                          (WA3W !== e.wa3) || (VectorResultW !== e.vec) ||
                          (e.chk_result && ResultW !== e.result) ||
                          (e.exp_cyc >= 0 && cyc != e.exp_cyc);
                    if (bad) begin
                        n_err++;
                        $display("FAIL sb_write cyc=%0d: got rw=%b mtr=%b vrw=%b wa3=%0d res=%h vec=%h, required rw=%b mtr=%b vrw=%b wa3=%0d res=%h vec=%h cyc=%0d",
                                 cyc, RegWriteW, MemToRegW, VectorRegWriteW, WA3W, ResultW, VectorResultW,
                                 e.rw, e.mtr, e.vrw, e.wa3, e.result, e.vec, e.exp_cyc);
                    end
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            ValidM  = 1'b0;
            ResultM = {$urandom, $urandom};
            @(negedge clk);
        end
    endtask

    // Present one instruction once the M stage is free; returns the accept cycle.
    task automatic issue(input logic vl, input logic rw, input logic mtr, input logic vrw,
                         input logic [4:0] wa3, input logic [63:0] res, input logic [63:0] vec,
                         output int t);
        exp_t e;
        int   guard = 0;
        while (StallM === 1'b1 && guard < 400) begin
            ValidM      = 1'($urandom);
            VectorLoadM = 1'($urandom);
            RegWriteM   = 1'($urandom);
            WA3M        = 5'($urandom);
            ResultM     = {$urandom, $urandom};
            @(negedge clk);
            guard++;
        end
        if (StallM === 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL issue_timeout: got StallM=1 for %0d cycles, required release", guard);
            ValidM = 1'b0;
            t = -1;
            return;
        end
        ValidM = 1'b1; VectorLoadM = vl; RegWriteM = rw; MemToRegM = mtr;
        VectorRegWriteM = vrw; WA3M = wa3; ResultM = res; VectorResultM = vec;
        t = cyc;
        if (vl) begin
            e.rw = 1'b0; e.mtr = 1'b0; e.vrw = 1'b1; e.wa3 = wa3; e.result = '0;
            e.vec = ref_vec(res); e.chk_result = 1'b0; e.exp_cyc = -1;
            sb.push_back(e);
        end else if (rw || mtr || vrw) begin
            e.rw = rw; e.mtr = mtr; e.vrw = vrw; e.wa3 = wa3; e.result = res;
            e.vec = vec; e.chk_result = 1'b1; e.exp_cyc = t + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        ValidM = 1'b0;
    endtask

    initial begin
        int t, ta, tb, vc0, guard;
        reset = 1'b1; ValidM = 1'b0; RegWriteM = 1'b0; MemToRegM = 1'b0;
        VectorLoadM = 1'b0; VectorRegWriteM = 1'b0; WA3M = '0; ResultM = '0; VectorResultM = '0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_RegWriteW", 64'(RegWriteW), 64'd0);
        chk("rst_MemToRegW", 64'(MemToRegW), 64'd0);
        chk("rst_VectorRegWriteW", 64'(VectorRegWriteW), 64'd0);
        chk("rst_WA3W", 64'(WA3W), 64'd0);
        chk("rst_ResultW", ResultW, 64'd0);
        chk("rst_VectorResultW", VectorResultW, 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_StallM", 64'(StallM), 64'd0);
        reset = 1'b0;
        idle(2);

        // Scalar pass-through, then the enable drops
        issue(1'b0, 1'b1, 1'b0, 1'b0, 5'd7, 64'h1234, {$urandom, $urandom}, t);
        chk("scalar_ResultW", ResultW, 64'h1234);
        @(negedge clk);
        chk("scalar_rw_drop", 64'(RegWriteW), 64'd0);
        idle(2);

        // Ideal-memory vector load
        hs_addr.delete();
        stall_cycles = 0;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 64'h100, '0, t);
        idle(10);
        chk("vl_nreq", 64'(hs_addr.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("vl_addr%0d", i), hs_addr[i], 64'h100 + 64'(2 * i));
        chk("vl_stall_cycles", 64'(stall_cycles), 64'd5);
        chk("vl_commit_cycle", 64'(last_vcommit), 64'(t + 6));
        chk("vl_data", last_vec, 64'h00A3_00A2_00A1_00A0);

        // Back-pressure on the second request
        ready_mode = 2; hold_left = 2;
        hs_addr.delete(); held.delete();
        issue(1'b1, 1'b0, 1'b0, 1'b0, 5'd4, 64'h100, '0, t);
        idle(12);
        chk("bp_nheld", 64'(held.size()), 64'd2);
        for (int i = 0; i < held.size(); i++) chk($sformatf("bp_held%0d", i), held[i], 64'h102);
        chk("bp_commit_cycle", 64'(last_vcommit), 64'(t + 8));
        chk("bp_data", last_vec, 64'h00A3_00A2_00A1_00A0);
        ready_mode = 0;

        // Address wrap
        hs_addr.delete();
        issue(1'b1, 1'b1, 1'b1, 1'b0, 5'd12, 64'hFFFF_FFFF_FFFF_FFFC, '0, t);
        idle(10);
        chk("wrap_nreq", 64'(hs_addr.size()), 64'd4);
        chk("wrap_addr0", hs_addr[0], 64'hFFFF_FFFF_FFFF_FFFC);
        chk("wrap_addr1", hs_addr[1], 64'hFFFF_FFFF_FFFF_FFFE);
        chk("wrap_addr2", hs_addr[2], 64'h0);
        chk("wrap_addr3", hs_addr[3], 64'h2);

        // Reset after two responses abandons the load
        issue(1'b1, 1'b0, 1'b0, 1'b0, 5'd6, 64'h200, '0, t);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        sb.delete();
        reset = 1'b0;
        chk("mid_rst_StallM", 64'(StallM), 64'd0);
        chk("mid_rst_mem_req", 64'(mem_req), 64'd0);
        chk("mid_rst_mem_addr", mem_addr, 64'd0);
        chk("mid_rst_VectorRegWriteW", 64'(VectorRegWriteW), 64'd0);
        chk("mid_rst_ResultW", ResultW, 64'd0);
        vc0 = vcommits;
        idle(10);
        chk("mid_rst_no_commit", 64'(vcommits), 64'(vc0));

        // Back-to-back loads: second accepted in the first one's COMMIT
        vc0 = vcommits;
        issue(1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 64'h300, '0, ta);
        issue(1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 64'h440, '0, tb);
        idle(10);
        chk("b2b_accept_cycle", 64'(tb), 64'(ta + 6));
        chk("b2b_commit_cycle", 64'(last_vcommit), 64'(tb + 6));
        chk("b2b_commits", 64'(vcommits - vc0), 64'd2);

        // Random traffic with memory back-pressure and variable latency
        ready_mode = 1; lat_mode = 1;
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 3) == 0)
                issue(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                      {$urandom, $urandom}, {$urandom, $urandom}, t);
            else
                issue(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                      {$urandom, $urandom}, {$urandom, $urandom}, t);
            idle($urandom_range(0, 2));
        end
        lat_mode = 0; ready_mode = 0;
        guard = 0;
        while ((sb.size() > 0 || StallM === 1'b1) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        idle(3);
        chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
